dmem_responder: RTL and testbench

- Memory-side responder for the data-memory request/acknowledge handshake issued by the memory-access stage.
- Holds a word-organised RAM and accepts one read or write at a time.
- Inserts a configurable number of wait states, applies byte/half/word write lanes from funct3, and reports misaligned or out-of-range accesses through an error flag.
- Sits outside the core: it is the slave end of the CPU data port in simulation tops and FPGA builds.

---
 rtl/arvi_dmem_pkg.sv | 52 +++++
 rtl/dmem_ram.sv | 39 +++
 rtl/dmem_responder.sv | 157 +++++++++++++++
 tb/tb_dmem_responder.sv | 179 +++++++++++++++++
 4 files changed

// File: rtl/arvi_dmem_pkg.sv
// Shared types and lane helpers for the data-memory responder.
// Decodes the access size into byte enables and write-lane replication.
package arvi_dmem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef struct packed {
    logic [3:0] be;
    logic       misaligned;
  } lane_t;

  // Illegal sizes are reported through the misaligned flag so one check rejects both.
  function automatic lane_t be_from_f3(input logic [2:0] f3, input logic [1:0] a);
    lane_t r;
    r.be         = 4'b0000;
    r.misaligned = 1'b0;
    case (f3)
      F3_B, F3_BU: r.be = 4'b0001 << a;
      F3_H, F3_HU: begin
        r.be         = a[1] ? 4'b1100 : 4'b0011;
        r.misaligned = a[0];
      end
      F3_W: begin
        r.be         = 4'b1111;
        r.misaligned = (a != 2'b00);
      end
      default: r.misaligned = 1'b1;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] lanes_from_f3(input logic [2:0] f3, input logic [31:0] d);
    logic [31:0] r;
    case (f3)
      F3_B, F3_BU: r = {4{d[7:0]}};
      F3_H, F3_HU: r = {2{d[15:0]}};
      default:     r = d;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/dmem_ram.sv
// Single-port word RAM with byte-lane writes and a registered, clearable read port.
// The read is read-first: a write cycle returns the word as it was before the write.
module dmem_ram #(
  parameter int    MEM_WORDS = 1024,
  parameter string INIT_FILE = ""
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic                         clr,
  input  logic [3:0]                   we,
  input  logic [$clog2(MEM_WORDS)-1:0] addr,
  input  logic [31:0]                  wdata,
  output logic [31:0]                  rdata
);

  logic [31:0] mem [MEM_WORDS];

  // Byte-lane write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (en) begin
      for (int i = 0; i < 4; i++) begin
        if (we[i]) begin
          mem[addr][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
  end

  // Read register holds until the next access; rejected accesses return zero.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= 32'h0000_0000;
    end else if (en) begin
      rdata <= clr ? 32'h0000_0000 : mem[addr];
    end
  end

endmodule

// File: rtl/dmem_responder.sv
// Slave end of the CPU data port: one access at a time, programmable wait states,
// alignment/range checking, and a one-cycle ack with error flag.
module dmem_responder
  import arvi_dmem_pkg::*;
#(
  parameter int          MEM_WORDS   = 1024,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000,
  parameter int          WAIT_CYCLES = 1,
  parameter string       INIT_FILE   = ""
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_rd_en,
  input  logic        i_wr_en,
  input  logic [31:0] i_addr,
  input  logic [31:0] i_wr_data,
  input  logic [2:0]  i_f3,
  output logic [31:0] o_rd_data,
  output logic        o_ack,
  output logic        o_err
);

  localparam int          AW      = $clog2(MEM_WORDS);
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);
  localparam logic [32:0] SPAN    = 33'(MEM_WORDS) << 2;

  state_t      state_r, state_s;
  logic [3:0]  cnt_r, cnt_s;
  logic [31:0] addr_r, data_r;
  logic [2:0]  f3_r;
  logic        wr_r, both_r;
  logic        ack_r, err_r;

  logic [31:0] acc_addr_s, acc_data_s, off_s;
  logic [2:0]  acc_f3_s;
  logic        acc_wr_s, acc_both_s;
  lane_t       lane_s;
  logic        in_range_s, err_s, req_s, latch_s, enter_resp_s;
  logic [3:0]  we_s;

  assign req_s = i_rd_en | i_wr_en;

  // In IDLE the live request is used so a zero-wait access completes without the latch.
  always_comb begin
    acc_addr_s = addr_r;
    acc_data_s = data_r;
    acc_f3_s   = f3_r;
    acc_wr_s   = wr_r;
    acc_both_s = both_r;
    if (state_r == IDLE) begin
      acc_addr_s = i_addr;
      acc_data_s = i_wr_data;
      acc_f3_s   = i_f3;
      acc_wr_s   = i_wr_en;
      acc_both_s = i_rd_en & i_wr_en;
    end else begin
      acc_addr_s = addr_r;
    end
    off_s      = acc_addr_s - BASE_ADDR;
    in_range_s = (acc_addr_s >= BASE_ADDR) && ({1'b0, off_s} < SPAN);
    lane_s     = be_from_f3(acc_f3_s, acc_addr_s[1:0]);
    err_s      = lane_s.misaligned | ~in_range_s | acc_both_s;
    if (enter_resp_s && acc_wr_s && !err_s) begin
      we_s = lane_s.be;
    end else begin
      we_s = 4'b0000;
    end
  end

  // Next-state and wait counter; a withdrawn request in WAIT aborts silently.
  always_comb begin
    state_s      = state_r;
    cnt_s        = cnt_r;
    latch_s      = 1'b0;
    enter_resp_s = 1'b0;
    case (state_r)
      IDLE: begin
        if (req_s) begin
          latch_s = 1'b1;
          cnt_s   = WAIT_LD;
          if (WAIT_LD == 4'd0) begin
            state_s      = RESP;
            enter_resp_s = 1'b1;
          end else begin
            state_s = WAIT;
          end
        end else begin
          state_s = IDLE;
        end
      end
      WAIT: begin
        if (!req_s) begin
          state_s = IDLE;
          cnt_s   = 4'd0;
        end else if (cnt_r <= 4'd1) begin
          state_s      = RESP;
          enter_resp_s = 1'b1;
          cnt_s        = 4'd0;
        end else begin
          cnt_s = cnt_r - 4'd1;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State, counter and response registers.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      state_r <= IDLE;
      cnt_r   <= 4'd0;
      ack_r   <= 1'b0;
      err_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cnt_r   <= cnt_s;
      ack_r   <= enter_resp_s;
      err_r   <= enter_resp_s & err_s;
    end
  end

  // Request latch captured when IDLE accepts a request.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      addr_r <= 32'h0000_0000;
      data_r <= 32'h0000_0000;
      f3_r   <= 3'b000;
      wr_r   <= 1'b0;
      both_r <= 1'b0;
    end else if (latch_s) begin
      addr_r <= i_addr;
      data_r <= i_wr_data;
      f3_r   <= i_f3;
      wr_r   <= i_wr_en;
      both_r <= i_rd_en & i_wr_en;
    end
  end

  dmem_ram #(
    .MEM_WORDS (MEM_WORDS),
    .INIT_FILE (INIT_FILE)
  ) u_ram (
    .clk   (i_clk),
    .rst_n (i_rst),
    .en    (enter_resp_s),
    .clr   (err_s),
    .we    (we_s),
    .addr  (off_s[AW+1:2]),
    .wdata (lanes_from_f3(acc_f3_s, acc_data_s)),
    .rdata (o_rd_data)
  );

  assign o_ack = ack_r;
  assign o_err = err_r;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed scoreboard bench: three responders (1, 3 and 0 wait states) driven in turn.
module tb_dmem_responder;

  typedef struct packed {
    logic        err;
    logic [31:0] data;
    logic        chk;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n   [3];
  logic        rd_en   [3];
  logic        wr_en   [3];
  logic [31:0] addr    [3];
  logic [31:0] wdata   [3];
  logic [2:0]  f3s     [3];
  logic [31:0] rd_data [3];
  logic        ack     [3];
  logic        err     [3];

  exp_t sb[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  dmem_responder #(.MEM_WORDS(64), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(1), .INIT_FILE("")) u_w1 (
    .i_clk(clk), .i_rst(rst_n[0]), .i_rd_en(rd_en[0]), .i_wr_en(wr_en[0]), .i_addr(addr[0]),
    .i_wr_data(wdata[0]), .i_f3(f3s[0]), .o_rd_data(rd_data[0]), .o_ack(ack[0]), .o_err(err[0]));

  dmem_responder #(.MEM_WORDS(64), .BASE_ADDR(32'h0000_0000), .WAIT_CYCLES(3), .INIT_FILE("")) u_w3 (
    .i_clk(clk), .i_rst(rst_n[1]), .i_rd_en(rd_en[1]), .i_wr_en(wr_en[1]), .i_addr(addr[1]),
    .i_wr_data(wdata[1]), .i_f3(f3s[1]), .o_rd_data(rd_data[1]), .o_ack(ack[1]), .o_err(err[1]));

  dmem_responder #(.MEM_WORDS(64), .BASE_ADDR(32'h0000_1000), .WAIT_CYCLES(0), .INIT_FILE("")) u_w0 (
    .i_clk(clk), .i_rst(rst_n[2]), .i_rd_en(rd_en[2]), .i_wr_en(wr_en[2]), .i_addr(addr[2]),
    .i_wr_data(wdata[2]), .i_f3(f3s[2]), .o_rd_data(rd_data[2]), .o_ack(ack[2]), .o_err(err[2]));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic issue(input int u, input logic rd, input logic wr, input logic [31:0] a,
                       input logic [31:0] d, input logic [2:0] f3, input logic e_err,
                       input logic [31:0] e_data, input logic chk);
    rd_en[u] = rd;
    wr_en[u] = wr;
    addr[u]  = a;
    wdata[u] = d;
    f3s[u]   = f3;
    sb.push_back('{e_err, e_data, chk});
  endtask

  task automatic wait_ack(input int u, input int lat, input string tag);
    int   n;
    logic got;
    exp_t e;
    n   = 0;
    got = 1'b0;
    while (!got && n < 64) begin
      @(posedge clk);
      #1;
      n++;
      got = ack[u];
    end
    check({tag, "_ack"}, 32'(got), 32'd1);
    check({tag, "_lat"}, 32'(n), 32'(lat));
    e = sb.pop_front();
    check({tag, "_err"}, 32'(err[u]), 32'(e.err));
    if (e.chk) check({tag, "_data"}, rd_data[u], e.data);
  endtask

  task automatic release_req(input int u, input string tag);
    rd_en[u] = 1'b0;
    wr_en[u] = 1'b0;
    @(posedge clk);
    #1;
    check({tag, "_ack_one_cycle"}, 32'(ack[u]), 32'd0);
  endtask

  task automatic access(input int u, input logic rd, input logic wr, input logic [31:0] a,
                        input logic [31:0] d, input logic [2:0] f3, input logic e_err,
                        input logic [31:0] e_data, input logic chk, input int lat, input string tag);
    issue(u, rd, wr, a, d, f3, e_err, e_data, chk);
    wait_ack(u, lat, tag);
    release_req(u, tag);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic seen;
    for (int u = 0; u < 3; u++) begin
      rst_n[u] = 1'b0; rd_en[u] = 1'b0; wr_en[u] = 1'b0;
      addr[u] = 32'h0; wdata[u] = 32'h0; f3s[u] = 3'b010;
    end
    @(posedge clk);
    #1;
    check("rst_ack", 32'(ack[0]), 32'd0);
    check("rst_err", 32'(err[0]), 32'd0);
    check("rst_rd_data", rd_data[0], 32'h0);
    check("rst_ack_w3", 32'(ack[1]), 32'd0);
    for (int u = 0; u < 3; u++) rst_n[u] = 1'b1;
    @(posedge clk);
    #1;

    // One wait state: basic write/read, lanes, errors.
    access(0, 1'b0, 1'b1, 32'h10, 32'hDEAD_BEEF, 3'b010, 1'b0, 32'h0, 1'b0, 2, "wr_word");
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0, 32'hDEAD_BEEF, 1'b1, 2, "rd_word");
    access(0, 1'b0, 1'b1, 32'h10, 32'h0, 3'b010, 1'b0, 32'h0, 1'b0, 2, "wr_zero");
    access(0, 1'b0, 1'b1, 32'h13, 32'h0000_00AA, 3'b000, 1'b0, 32'h0, 1'b0, 2, "wr_byte");
    access(0, 1'b0, 1'b1, 32'h10, 32'h0000_1234, 3'b001, 1'b0, 32'h0, 1'b0, 2, "wr_half");
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0, 32'hAA00_1234, 1'b1, 2, "rd_lanes");
    access(0, 1'b0, 1'b1, 32'h11, 32'hFFFF_FFFF, 3'b001, 1'b1, 32'h0, 1'b1, 2, "half_misal");
    access(0, 1'b1, 1'b0, 32'h12, 32'h0, 3'b010, 1'b1, 32'h0, 1'b1, 2, "word_misal");
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0, 32'hAA00_1234, 1'b1, 2, "rd_after_misal");
    access(0, 1'b1, 1'b0, 32'h100, 32'h0, 3'b010, 1'b1, 32'h0, 1'b1, 2, "out_of_range");
    access(0, 1'b1, 1'b1, 32'h10, 32'hFFFF_FFFF, 3'b010, 1'b1, 32'h0, 1'b1, 2, "rd_and_wr");
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b011, 1'b1, 32'h0, 1'b1, 2, "f3_011");
    access(0, 1'b0, 1'b1, 32'h10, 32'hFFFF_FFFF, 3'b110, 1'b1, 32'h0, 1'b1, 2, "f3_110");
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0, 32'hAA00_1234, 1'b1, 2, "rd_unchanged");
    access(0, 1'b0, 1'b1, 32'h11, 32'h0000_0055, 3'b100, 1'b0, 32'h0, 1'b0, 2, "wr_bu");
    access(0, 1'b0, 1'b1, 32'h12, 32'h0000_BEEF, 3'b101, 1'b0, 32'h0, 1'b0, 2, "wr_hu");
    access(0, 1'b1, 1'b0, 32'h10, 32'h0, 3'b010, 1'b0, 32'hBEEF_5534, 1'b1, 2, "rd_upper");
    access(0, 1'b0, 1'b1, 32'hFC, 32'h1234_5678, 3'b010, 1'b0, 32'h0, 1'b0, 2, "wr_top");
    access(0, 1'b1, 1'b0, 32'hFC, 32'h0, 3'b010, 1'b0, 32'h1234_5678, 1'b1, 2, "rd_top");

    // Three wait states: withdrawn write and reset mid-wait.
    access(1, 1'b0, 1'b1, 32'h20, 32'h0BAD_F00D, 3'b010, 1'b0, 32'h0, 1'b0, 4, "w3_wr");
    wr_en[1] = 1'b1; addr[1] = 32'h20; wdata[1] = 32'h1111_1111; f3s[1] = 3'b010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    wr_en[1] = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      seen = seen | ack[1];
    end
    check("withdraw_no_ack", 32'(seen), 32'd0);
    access(1, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 1'b0, 32'h0BAD_F00D, 1'b1, 4, "w3_rd_after_withdraw");
    rd_en[1] = 1'b1; addr[1] = 32'h20; f3s[1] = 3'b010;
    @(posedge clk); #1;
    @(posedge clk); #1;
    rst_n[1] = 1'b0;
    #1;
    check("midwait_rst_ack", 32'(ack[1]), 32'd0);
    check("midwait_rst_rd_data", rd_data[1], 32'h0);
    rd_en[1] = 1'b0;
    @(posedge clk); #1;
    rst_n[1] = 1'b1;
    @(posedge clk); #1;
    access(1, 1'b1, 1'b0, 32'h20, 32'h0, 3'b010, 1'b0, 32'h0BAD_F00D, 1'b1, 4, "w3_rd_after_rst");

    // Zero wait states, non-zero base: range edges and a held read stream.
    access(2, 1'b1, 1'b0, 32'h0FFC, 32'h0, 3'b010, 1'b1, 32'h0, 1'b1, 1, "below_base");
    access(2, 1'b1, 1'b0, 32'h1100, 32'h0, 3'b010, 1'b1, 32'h0, 1'b1, 1, "above_top");
    for (int i = 0; i < 8; i++) begin
      access(2, 1'b0, 1'b1, 32'h1000 + 32'(8 * i), 32'hC0DE_0000 | 32'(i), 3'b010,
             1'b0, 32'h0, 1'b0, 1, "w0_fill");
    end
    for (int i = 7; i >= 0; i--) begin
      issue(2, 1'b1, 1'b0, 32'h1000 + 32'(8 * i), 32'h0, 3'b010, 1'b0, 32'hC0DE_0000 | 32'(i), 1'b1);
      wait_ack(2, (i == 7) ? 1 : 2, "w0_stream");
    end
    release_req(2, "w0_stream_end");

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
